digit_serial_adder: RTL

Parametrised, multi-cycle adder/subtractor that processes WIDTH-bit operands one DIGIT-bit slice per clock, LSB slice first.
- Generalises the single-bit full-adder cell: adds width, a carry chain stored across cycles, a subtract mode and a signed-overflow flag.
- Uses valid/ready handshakes on both sides, so it sits between operand sources and result consumers in the arithmetic datapath.

---
 rtl/digit_serial_adder.sv | 102 ++++++++++
 1 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock,
// LSB digit first, with valid/ready handshakes on the operand and result sides.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_valid/in_ready move operands in (IDLE only); out_valid/out_ready move the result out (DONE only).
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt, s_ext;
  logic [CW-1:0]    cnt;
  logic             c, c_nxt, a_msb, b_msb;
  logic [DIGIT:0]   dig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)       state_nxt = RUN;
      RUN:     if (cnt == LAST)    state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  // One digit of the carry chain; the digit sum enters the result from the top.
  always_comb begin
    dig     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, c};
    c_nxt   = dig[DIGIT];
    s_ext   = WIDTH'(dig[DIGIT-1:0]);
    res_nxt = (res_sh >> DIGIT) | (s_ext << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      // Subtraction is a + ~b + 1; a borrow-in removes the +1.
      a_sh   <= a;
      b_sh   <= sub ? ~b : b;
      c      <= cin ^ sub;
      cnt    <= '0;
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1] ^ sub;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      res_sh <= res_nxt;
      c      <= c_nxt;
      cnt    <= cnt + CW'(1);
      if (cnt == LAST) begin
        sum  <= res_nxt;
        cout <= c_nxt;
        ovf  <= (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);
      end
    end
  end
endmodule
